// File: rtl/alu_rr_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_sched_if
//  Purpose  : Bundle of the request, ALU and response channels of the
//             round-robin ALU scheduler.
//  Ports    : req0_* / req1_*  request channels (valid/ready, a, b, opt)
//             alu_*            operands out to the ALU, result/flags back
//             rsp_*            response channel (valid/ready, id, result, flags)
//             busy             scheduler is in EXEC or RESP
//  Modports : slave  - the scheduler
//             master - the environment (requesters, ALU, response consumer)
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_rr_sched_if #(
    parameter int DW = 4,
    parameter int OW = 3,
    parameter int NF = 5
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [OW-1:0] req0_opt;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [OW-1:0] req1_opt;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [OW-1:0] alu_opt;
    logic [DW-1:0] alu_result;
    logic [NF-1:0] alu_flags;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_result;
    logic [NF-1:0] rsp_flags;

    logic          busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_opt,
        input  req1_valid, req1_a, req1_b, req1_opt,
        input  alu_result, alu_flags, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_opt,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_opt,
        output req1_valid, req1_a, req1_b, req1_opt,
        output alu_result, alu_flags, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_opt,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_sched
//  Purpose  : Round-robin scheduler sharing one external 4-bit combinational
//             ALU between two requesters. The winning request is registered,
//             presented to the ALU for one cycle, and the result/flags are
//             captured and returned with the requester ID.
//  Ports    : clk    - system clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - alu_rr_sched_if.slave (request, ALU, response channels)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_rr_sched #(
    parameter int DW = 4,   // tied to the ALU width; do not override
    parameter int OW = 3,
    parameter int NF = 5
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_rr_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [OW-1:0] r_op_opt;
    logic          r_id;
    logic          r_last_grant;
    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_result;
    logic [NF-1:0] r_rsp_flags;

    logic          w_grant;
    logic          w_ready0;
    logic          w_ready1;
    logic          w_hs;

    // On contention the requester that did not win last time gets the slot;
    // with a single requester the grant simply follows its valid.
    assign w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant
                                                         : bus.req1_valid;

    // rst_n gating keeps both readies low while reset is held, even if a
    // requester is already presenting valid.
    assign w_ready0 = rst_n && (r_state == IDLE) && bus.req0_valid && !w_grant;
    assign w_ready1 = rst_n && (r_state == IDLE) && bus.req1_valid &&  w_grant;
    assign w_hs     = w_ready0 || w_ready1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_opt     <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;    // requester 0 wins the first contention
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_op_a   <= w_ready1 ? bus.req1_a   : bus.req0_a;
                        r_op_b   <= w_ready1 ? bus.req1_b   : bus.req0_b;
                        r_op_opt <= w_ready1 ? bus.req1_opt : bus.req0_opt;
                        r_id     <= w_ready1;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU has had the full cycle on the latched operands.
                    r_rsp_result <= bus.alu_result;
                    r_rsp_flags  <= bus.alu_flags;
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_last_grant <= r_id;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;

    assign bus.alu_a      = r_op_a;
    assign bus.alu_b      = r_op_b;
    assign bus.alu_opt    = r_op_opt;

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;

    assign bus.busy       = (r_state == EXEC) || (r_state == RESP);

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_rr_sched
//  Purpose  : Self-checking bench for alu_rr_sched. Contains a small signed
//             4-bit ALU model driven from the scheduler's ALU outputs, a
//             directed stimulus sequence and a scoreboard monitor that pops
//             hand-computed expected responses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sched;

    localparam int DW = 4;
    localparam int OW = 3;
    localparam int NF = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LESS = 3'b110;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_sched_if #(.DW(DW), .OW(OW), .NF(NF)) bus ();

    alu_rr_sched #(.DW(DW), .OW(OW), .NF(NF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- ALU model: flags {less, equal, carry, overflow, zero}
    logic       m_sub;
    logic [4:0] m_sum;
    logic [3:0] m_res;
    logic       m_c, m_v, m_z, m_l, m_e;
    always_comb begin
        m_sub = (bus.alu_opt == OP_SUB) || (bus.alu_opt == OP_LESS);
        m_sum = {1'b0, bus.alu_a} + {1'b0, (m_sub ? ~bus.alu_b : bus.alu_b)} + {4'b0, m_sub};
        m_res = bus.alu_a ^ bus.alu_b;
        m_c   = 1'b0;
        m_v   = 1'b0;
        if (bus.alu_opt == OP_ADD || m_sub) begin
            m_res = m_sum[3:0];
            m_c   = m_sum[4];
            m_v   = m_sub ? ((bus.alu_a[3] != bus.alu_b[3]) && (m_res[3] != bus.alu_a[3]))
                          : ((bus.alu_a[3] == bus.alu_b[3]) && (m_res[3] != bus.alu_a[3]));
        end
        m_z = (m_res == 4'd0);
        m_l = (bus.alu_opt == OP_LESS) && ($signed(bus.alu_a) < $signed(bus.alu_b));
        m_e = (bus.alu_opt == OP_LESS) && (bus.alu_a == bus.alu_b);
        bus.alu_result = m_res;
        bus.alu_flags  = {m_l, m_e, m_c, m_v, m_z};
    end

    // ---------------- scoreboard
    typedef struct {
        logic       id;
        logic [3:0] res;
        logic [4:0] flg;
    } exp_t;
    exp_t exp_q[$];

    int checks       = 0;
    int failures     = 0;
    int cyc          = 0;
    int acc_cyc      = 0;
    int both_high    = 0;
    int ready_pulses = 0;
    int n_sent       = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic [3:0] res, input logic [4:0] flg);
        exp_t e;
        e.id = id; e.res = res; e.flg = flg;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.req0_ready && bus.req1_ready) both_high++;
                if (bus.req0_ready || bus.req1_ready) begin
                    ready_pulses++;
                    acc_cyc = cyc;
                end
                if (bus.rsp_valid && !prev_valid)
                    chk("rsp_latency", cyc, acc_cyc + 2);
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_flags}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id",     bus.rsp_id,     e.id);
                        chk("rsp_result", bus.rsp_result, e.res);
                        chk("rsp_flags",  bus.rsp_flags,  e.flg);
                    end
                end
                prev_valid = bus.rsp_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] opt);
        logic ok;
        ok = 1'b0;
        if (!id) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_opt = opt; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_opt = opt; bus.req1_valid = 1'b1;
        end
        n_sent++;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", ok, 1);
        @(posedge clk);
        #1;
        if (!id) bus.req0_valid = 1'b0;
        else     bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] opt,
                        input logic [3:0] res, input logic [4:0] flg);
        push(id, res, flg);
        issue(id, a, b, opt);
        drain();
    endtask

    function automatic logic [31:0] all_outputs();
        return {7'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.busy,
                bus.alu_a, bus.alu_b, bus.alu_opt, bus.req0_ready, bus.req1_ready};
    endfunction

    // ---------------- directed sequence
    initial begin
        logic [9:0] snap;
        logic       seen;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_opt = OP_ADD;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_opt = OP_ADD;
        bus.rsp_ready  = 1'b1;

        #2;
        chk("reset_outputs", all_outputs(), 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;

        // basic single-requester vectors
        send(1'b0, 4'd3,    4'd4, OP_ADD,  4'd7,    5'b00000);
        send(1'b1, 4'd7,    4'd1, OP_ADD,  4'b1000, 5'b00010);
        send(1'b0, 4'b1110, 4'd1, OP_LESS, 4'b1101, 5'b10100);
        send(1'b0, 4'd5,    4'd5, OP_SUB,  4'd0,    5'b00101);
        send(1'b1, 4'd2,    4'd5, OP_SUB,  4'b1101, 5'b00000);

        // contention: last grant was 1, so order must be 0,1,0,1
        push(1'b0, 4'd3, 5'b00000);
        push(1'b1, 4'd4, 5'b00100);
        push(1'b0, 4'd8, 5'b00010);
        push(1'b1, 4'd0, 5'b00101);
        fork
            begin
                issue(1'b0, 4'd1, 4'd2, OP_ADD);
                issue(1'b0, 4'd4, 4'd4, OP_ADD);
            end
            begin
                issue(1'b1, 4'd6,  4'd2, OP_SUB);
                issue(1'b1, 4'd15, 4'd1, OP_ADD);
            end
        join
        drain();

        // response back-pressure
        bus.rsp_ready = 1'b0;
        push(1'b0, 4'd0, 5'b01101);
        issue(1'b0, 4'd3, 4'd3, OP_LESS);
        push(1'b1, 4'd5, 5'b00000);
        bus.req1_a = 4'd2; bus.req1_b = 4'd3; bus.req1_opt = OP_ADD; bus.req1_valid = 1'b1;
        n_sent++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("stall_rsp_valid", seen, 1);
        snap = {bus.rsp_id, bus.rsp_result, bus.rsp_flags};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold",   {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags}, {1'b1, snap});
            chk("stall_ready",  {bus.req0_ready, bus.req1_ready}, 0);
            chk("stall_busy",   bus.busy, 1);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("next_accept", {bus.req1_ready, bus.busy}, 2'b10);
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
        drain();

        // reset in the middle of EXEC drops the transaction
        issue(1'b0, 4'd3, 4'd4, OP_ADD);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", all_outputs(), 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", {bus.rsp_valid, bus.busy}, 0);
        end
        @(posedge clk);
        #1;
        push(1'b0, 4'b1011, 5'b00010);
        push(1'b1, 4'b1111, 5'b00000);
        fork
            issue(1'b0, 4'd5, 4'd6, OP_ADD);
            issue(1'b1, 4'd0, 4'd1, OP_SUB);
        join
        drain();

        chk("both_ready_high", both_high, 0);
        chk("ready_pulses", ready_pulses, n_sent);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
